b_add: RTL and testbench
========================

// Module: b_add
// PURPOSE
//   Registered unsigned binary adder: oC = iA + iB, full-precision (one extra carry bit).
//   Binary baseline arithmetic block in the scu hardware set, used as reference datapath
//   against unary/stochastic adders. Fixed 2-cycle latency, fully pipelined (1 result/cycle).
// PARAMETERS
//   DATAWD   8   operand width in bits (also provided as shared package constant / `DATAWD)
// PORTS
//   clk    in   1         single clock, all state on rising edge
//   rst_n  in   1         asynchronous reset, active-low
//   iA     in   DATAWD    unsigned operand A
//   iB     in   DATAWD    unsigned operand B
//   oC     out  DATAWD+1  unsigned sum, MSB = carry out
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous and active-low (rst_n).
//   - Reset: while rst_n=0, all internal registers and oC are 0 immediately (no clock
//     needed). The first clk rising edge after rst_n rises captures operands normally.
//   - Stage 1 (edge k): register iA, iB into a_q, b_q.
//   - Stage 2 (edge k+1): oC <= a_q + b_q, zero-extended to DATAWD+1 bits before adding.
//   - Latency: operands present before edge k appear on oC after edge k+1 (2 edges).
//   - Throughput: new operands accepted every cycle; no handshake, no valid, no stall.
//   - Arithmetic: unsigned, no saturation, no wrap; carry always lands in oC[DATAWD].
//     Max result (2^DATAWD-1)*2 fits exactly in DATAWD+1 bits.
//   - Inputs held constant -> oC constant from the 2nd edge on.
//   - Reset mid-stream: in-flight operands discarded; oC=0 until 2 edges after release.
//   - oC is purely registered (no combinational path from iA/iB to oC).
//   - No X propagation from reset: all registers have explicit reset values.
// STRUCTURE
//   - Package b_add_pkg: localparam DATAWD=8; typedef logic [DATAWD-1:0] operand_t;
//     typedef logic [DATAWD:0] sum_t.
//   - Sub-module b_add_rca: combinational ripple-carry adder built from a generate loop
//     of full-adder bit cells (inputs a,b: operand_t, cin=0; output sum_t). b_add
//     instantiates it between the stage-1 and stage-2 registers.
//   - Top b_add: stage-1 operand registers, b_add_rca instance, stage-2 result register.
// TESTING
//   1. rst_n=0 with iA=iB=128 -> oC=0 throughout reset, independent of clk.
//   2. Release rst_n, hold iA=128,iB=128 -> oC=256 (9'h100) from 2nd edge, stays 256.
//   3. iA=255,iB=255 -> oC=510 (9'h1FE); iA=0,iB=0 -> oC=0; iA=255,iB=1 -> oC=256.
//   4. Back-to-back: (1,2),(3,4),(100,27) on consecutive edges -> oC=3,7,127 on
//      consecutive cycles, each 2 edges after its operands.
//   5. Assert rst_n mid-stream between edges -> oC drops to 0 asynchronously; after
//      release, oC resumes correct sums 2 edges later, no stale values emitted.
//   6. Random unsigned operands, 1000 cycles -> oC equals iA+iB delayed by 2 cycles.

Source files
------------

// File: rtl/b_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : b_add_pkg
// Description : Shared constants and types for the registered binary adder.
//               DATAWD is the operand width; sum_t carries one extra bit so
//               the carry out is never lost.
// Revision    : 1.0 - initial release
// ============================================================================
package b_add_pkg;

  localparam int DATAWD = 8;

  typedef logic [DATAWD-1:0] operand_t;
  typedef logic [DATAWD:0]   sum_t;

endpackage : b_add_pkg
`default_nettype wire

// File: rtl/b_add_rca.sv
`default_nettype none
// ============================================================================
// Module      : b_add_rca
// Description : Purely combinational ripple-carry adder built from DATAWD
//               full-adder bit cells. The carry out of the top cell becomes
//               the MSB of the result, so the sum is full precision.
// Ports       : a    in  operand_t  addend A
//               b    in  operand_t  addend B
//               cin  in  1          carry into bit 0
//               sum  out sum_t      a + b + cin, MSB = carry out
// Revision    : 1.0 - initial release
// ============================================================================
module b_add_rca
  import b_add_pkg::*;
(
  input  operand_t a,
  input  operand_t b,
  input  logic     cin,
  output sum_t     sum
);

  // Each cell owns its own carry-in/carry-out nets; the chain is formed by
  // referencing the previous cell's carry out.
  for (genvar i = 0; i < DATAWD; i++) begin : g_fa
    logic w_cin;
    logic w_cout;
    logic w_prop;

    if (i == 0) begin : g_lsb
      assign w_cin = cin;
    end else begin : g_chain
      assign w_cin = g_fa[i-1].w_cout;
    end

    assign w_prop = a[i] ^ b[i];
    assign sum[i] = w_prop ^ w_cin;
    assign w_cout = (a[i] & b[i]) | (w_prop & w_cin);
  end : g_fa

  assign sum[DATAWD] = g_fa[DATAWD-1].w_cout;

endmodule : b_add_rca
`default_nettype wire

// File: rtl/b_add.sv
`default_nettype none
// ============================================================================
// Module      : b_add
// Description : Registered unsigned binary adder, oC = iA + iB with one
//               extra carry bit. Two-stage pipeline: operands are registered
//               on the first edge, the sum is registered on the second. One
//               new result per cycle, no handshake.
// Ports       : clk    in  1         clock, rising edge
//               rst_n  in  1         asynchronous reset, active low
//               iA     in  DATAWD    unsigned operand A
//               iB     in  DATAWD    unsigned operand B
//               oC     out DATAWD+1  registered sum, MSB = carry out
// Revision    : 1.0 - initial release
// ============================================================================
module b_add
  import b_add_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATAWD-1:0] iA,
  input  logic [DATAWD-1:0] iB,
  output logic [DATAWD:0]   oC
);

  operand_t r_a_q;
  operand_t r_b_q;
  sum_t     w_sum;

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_q <= '0;
      r_b_q <= '0;
    end else begin
      r_a_q <= iA;
      r_b_q <= iB;
    end
  end

  // Adder sits between the two register stages, so oC has no
  // combinational path from the input ports.
  b_add_rca u_rca (
    .a   (r_a_q),
    .b   (r_b_q),
    .cin (1'b0),
    .sum (w_sum)
  );

  // Stage 2: result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oC <= '0;
    end else begin
      oC <= w_sum;
    end
  end

endmodule : b_add
`default_nettype wire

// File: tb/tb_b_add.sv
`default_nettype none
// ============================================================================
// Module      : tb_b_add
// Description : Scoreboard bench for b_add. Stimulus pushes the arithmetic
//               sum of each operand pair, tagged with the clock edge that
//               captured it; a monitor pops each entry one edge later and
//               compares it against oC. Reset drains the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_b_add;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] iA;
  logic [W-1:0] iB;
  logic [W:0]   oC;

  typedef struct {
    int sum;
    int edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt;
  int   n_checks;
  int   n_fail;

  b_add dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iA    (iA),
    .iB    (iB),
    .oC    (oC)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Edges since reset release; reset also discards everything in flight.
  initial begin
    edge_cnt = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        edge_cnt = 0;
        exp_q.delete();
      end else begin
        edge_cnt++;
      end
    end
  end

  // Monitor: a result captured on edge k must appear after edge k+1.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_hold", {23'd0, oC}, 32'd0);
      end else if (edge_cnt <= 1) begin
        chk("post_release_zero", {23'd0, oC}, 32'd0);
      end else if (exp_q.size() > 0) begin
        if (exp_q[0].edge_n == edge_cnt - 1) begin
          e = exp_q.pop_front();
          chk("sum", {23'd0, oC}, e.sum);
        end else if (exp_q[0].edge_n < edge_cnt - 1) begin
          e = exp_q.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missed_result: expected %0d never observed (edge %0d)", e.sum, e.edge_n);
        end
      end
    end
  end

  // Present one operand pair for exactly one capturing edge.
  task automatic issue(input int a, input int b);
    exp_t e;
    iA = a[W-1:0];
    iB = b[W-1:0];
    @(posedge clk);
    #1;
    if (rst_n) begin
      e.sum    = (a % 256) + (b % 256);
      e.edge_n = edge_cnt;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    iA       = 8'd128;
    iB       = 8'd128;

    // 1: held in reset with nonzero operands.
    #1;
    chk("reset_before_clock", {23'd0, oC}, 32'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // 2: constant operands give a constant 256 from the second edge on.
    repeat (5) issue(128, 128);

    // 3: corner values.
    issue(255, 255);
    issue(0, 0);
    issue(255, 1);
    issue(255, 0);
    issue(0, 255);

    // 4: back-to-back distinct pairs.
    issue(1, 2);
    issue(3, 4);
    issue(100, 27);

    // 5: asynchronous reset between edges, then recovery.
    issue(10, 20);
    issue(30, 40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_drop", {23'd0, oC}, 32'd0);
    iA = 8'd200;
    iB = 8'd100;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    issue(50, 60);
    issue(255, 255);
    issue(7, 9);

    // 6: random operands, including occasional extremes.
    for (int i = 0; i < 1000; i++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      if ((i % 97) == 0) a = 255;
      if ((i % 89) == 0) b = 255;
      issue(a, b);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_b_add
`default_nettype wire
